lampy_pwm_multi: RTL

LAMPY_PWM_MULTI -- requirements
Module: lampy_pwm_multi

---
 rtl/lampy_pwm_multi.sv | 124 ++++++++++++
 1 files changed

// File: rtl/lampy_pwm_multi.sv
// Multi-channel PWM LED driver with shared period counter and a per-channel
// static / breathe / blink animation driven by a common step prescaler.
module lampy_pwm_multi #(
  parameter int CHANNELS      = 3,
  parameter int PWM_BITS      = 8,
  parameter int CLOCK_FREQ_HZ = 24000000,
  parameter int STEP_HZ       = 1000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wr_ena,
  input  logic [3:0]          wr_ch,
  input  logic [1:0]          wr_mode,
  input  logic [PWM_BITS-1:0] wr_level,
  input  logic                sync,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start,
  output logic                step_tick
);

  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LAST     = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam int                  DIV      = CLOCK_FREQ_HZ / STEP_HZ;
  localparam int                  PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DIV - 1);
  localparam int                  PW       = 2 * PWM_BITS + 1;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_STATIC  = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;
  localparam logic [1:0] MODE_BLINK   = 2'd3;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    pre_cnt;
  logic                period_end;
  logic                wr_hit;

  logic [1:0]          mode_q   [CHANNELS];
  logic [PWM_BITS-1:0] level_q  [CHANNELS];
  logic [PWM_BITS-1:0] tri_q    [CHANNELS];
  logic                dir_down [CHANNELS];
  logic [PWM_BITS-1:0] duty_q   [CHANNELS];
  logic [PWM_BITS-1:0] target   [CHANNELS];

  // Scales the triangle by (level+1)/2^PWM_BITS so level MAX reaches full MAX.
  function automatic logic [PWM_BITS-1:0] breathe_duty(input logic [PWM_BITS-1:0] t,
                                                       input logic [PWM_BITS-1:0] l);
    logic [PW-1:0] p;
    p = PW'(t) * (PW'(l) + PW'(1));
    return PWM_BITS'(p >> PWM_BITS);
  endfunction

  assign period_end = (pwm_cnt == LAST);
  assign step_tick  = (pre_cnt == PRE_LAST);
  assign wr_hit     = wr_ena && ({28'd0, wr_ch} < CHANNELS);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pwm_cnt      <= '0;
      pre_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_cnt      <= period_end ? '0 : pwm_cnt + PWM_BITS'(1);
      pre_cnt      <= step_tick ? '0 : pre_cnt + PRE_W'(1);
      period_start <= period_end;
    end
  end

  // A write or sync restarts the triangle and outranks a coincident step.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pwm_out <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        mode_q[k]   <= MODE_OFF;
        level_q[k]  <= '0;
        tri_q[k]    <= '0;
        dir_down[k] <= 1'b0;
        duty_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if ((wr_hit && wr_ch == 4'(k)) || sync) begin
          tri_q[k]    <= '0;
          dir_down[k] <= 1'b0;
        end else if (step_tick) begin
          if (!dir_down[k]) begin
            if (tri_q[k] == MAX) begin
              dir_down[k] <= 1'b1;
              tri_q[k]    <= LAST;
            end else begin
              tri_q[k] <= tri_q[k] + PWM_BITS'(1);
            end
          end else if (tri_q[k] == '0) begin
            dir_down[k] <= 1'b0;
            tri_q[k]    <= PWM_BITS'(1);
          end else begin
            tri_q[k] <= tri_q[k] - PWM_BITS'(1);
          end
        end
        if (wr_hit && wr_ch == 4'(k)) begin
          mode_q[k]  <= wr_mode;
          level_q[k] <= wr_level;
        end
        if (period_end) begin
          duty_q[k] <= target[k];
        end
        pwm_out[k] <= (pwm_cnt < duty_q[k]);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      target[k] = '0;
      case (mode_q[k])
        MODE_STATIC:  target[k] = level_q[k];
        MODE_BREATHE: target[k] = breathe_duty(tri_q[k], level_q[k]);
        MODE_BLINK:   target[k] = dir_down[k] ? '0 : level_q[k];
        default:      target[k] = '0;
      endcase
    end
  end

endmodule
